// File: rtl/arb_pkg.sv
// Shared constants and helpers for the four-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    // Arbiter FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // One-hot (or zero) to binary index; matches the encoder/decoder pair.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr, mod 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [N_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0] pick_idx
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [N_REQ-1:0]   pick_rot;
    logic [2*N_REQ-1:0] pick_dbl;

    // Rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
    always_comb begin
        req_dbl     = {req, req};
        req_rot     = req_dbl[ptr +: N_REQ];
        pick_rot    = req_rot & (~req_rot + 4'd1);
        pick_dbl    = {pick_rot, pick_rot} << ptr;
        pick_onehot = pick_dbl[2*N_REQ-1:N_REQ];
        pick_idx    = onehot_to_idx(pick_onehot);
        found       = |req;
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and index.
// Optional hold-time limit enabled by defining ARB_HOLD_LIMIT_EN.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || (MAX_HOLD - 1) >= (1 << HOLD_W)) begin : g_param_check
        $error("rr_arbiter4: MAX_HOLD must be 2..255 and fit in HOLD_W bits");
    end

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [N_REQ-1:0] others;
    logic [IDX_W-1:0] owner_next;
    logic             owner_req;
    logic             release_now;
    logic [N_REQ-1:0] pick_req;
    logic [IDX_W-1:0] pick_ptr;
    logic             found;
    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;

`ifdef ARB_HOLD_LIMIT_EN
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_max;
`endif

    // Requests other than the owner, and where the search resumes after release
    always_comb begin
        others     = req & ~grant_q;
        owner_next = idx_q + 2'd1;
        owner_req  = |(req & grant_q);
        // In IDLE search all requests from ptr; in GRANT search the others from owner+1
        pick_req   = (state_q == ST_IDLE) ? req : others;
        pick_ptr   = (state_q == ST_IDLE) ? ptr_q : owner_next;
`ifdef ARB_HOLD_LIMIT_EN
        hold_max    = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
        release_now = !owner_req || (hold_max && |others);
`else
        release_now = !owner_req;
`endif
    end

    rr_pick4 u_pick (
        .req         (pick_req),
        .ptr         (pick_ptr),
        .found       (found),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx)
    );

    // Next-state logic for FSM, pointer, grant and hold counter
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        idx_d   = idx_q;
`ifdef ARB_HOLD_LIMIT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_GRANT;
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    ptr_d = owner_next;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_d = '0;
`endif
                    if (found) begin
                        // Hand over directly, no idle bubble
                        grant_d = pick_onehot;
                        idx_d   = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                    end
                end else begin
`ifdef ARB_HOLD_LIMIT_EN
                    // Saturate when nobody else is waiting
                    if (!hold_max) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            idx_q   <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rr_arbiter4.sv
// Randomized self-checking bench for rr_arbiter4 against a behavioural model.
module tb_rr_arbiter4;

    localparam int MAXH = 4;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;

    int checks;
    int errors;

    // Reference model state: owner -1 means idle
    int m_owner;
    int m_ptr;
    int m_cnt;

    rr_arbiter4 #(
        .MAX_HOLD (MAXH),
        .HOLD_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // First requester at or after p, wrapping; -1 when none
    function automatic int rr_search(input logic [3:0] mask, input int p);
        for (int k = 0; k < 4; k++) begin
            if (mask[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] q);
        logic [3:0] oth;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            m_owner = rr_search(q, m_ptr);
            m_cnt = 0;
        end else begin
            oth = q;
            oth[m_owner] = 1'b0;
            if (!q[m_owner] || (HOLD_EN && m_cnt == MAXH - 1 && oth != 4'b0)) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = rr_search(oth, m_ptr);
                m_cnt   = 0;
            end else if (m_cnt < MAXH - 1) begin
                m_cnt++;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        logic [1:0] ei;
        eg = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
        ei = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        check("grant", 32'(grant), 32'(eg));
        check("grant_idx", 32'(grant_idx), 32'(ei));
        check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    endtask

    // Called at a falling edge; applies inputs, advances one clock, checks
    task automatic step(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        model_edge(r, q);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [3:0] rq;
        checks  = 0;
        errors  = 0;
        m_owner = -1; m_ptr = 0; m_cnt = 0;
        rst = 1'b1;
        req = 4'b1111;
        @(negedge clk);

        // Reset with all requests pending, then first grant goes to 0
        step(1'b1, 4'b1111);
        check("rst_grant", 32'(grant), 32'h0);
        step(1'b0, 4'b1111);
        check("first_grant", 32'(grant), 32'h1);

        // Single requester 1 from idle with ptr=0
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        check("req1_grant", 32'(grant), 32'h2);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0000);
        check("req1_release", 32'(grant), 32'h0);

        // ptr now 2: 1011 goes to 3, then wraps to 0 with no bubble
        step(1'b0, 4'b1011);
        check("wrap_first", 32'(grant_idx), 32'd3);
        step(1'b0, 4'b0011);
        check("wrap_second", 32'(grant), 32'h1);
        step(1'b0, 4'b0000);

        // Two requesters held continuously: hold limit behaviour
        step(1'b1, 4'b0000);
        for (int i = 0; i < 20; i++) step(1'b0, 4'b0011);

        // Mid-grant reset while owner 2 is granted
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0100);
        step(1'b1, 4'b0100);
        check("mid_rst", 32'(grant), 32'h0);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0100);
        check("after_rst", 32'(grant), 32'h4);
        step(1'b0, 4'b0000);

        // Owner 0 holds while other bits churn
        step(1'b0, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0001 | 4'($urandom_range(0, 7) << 1));
            check("churn_idx", 32'(grant_idx), 32'd0);
        end

        // Random traffic, requests tend to persist
        rq = 4'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 30) rq = 4'($urandom_range(0, 15));
            step($urandom_range(0, 99) < 2, rq);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter for a shared resource.
- Produces a registered one-hot grant plus its 2-bit encoded index; the index is the same 4-to-2 encoding used by our encoder/decoder pair, so it can drive a downstream decoder/mux select.
- Sits between four masters and one shared datapath.
- Grant is held while the owner keeps requesting, with optional hold-time limit.

Parameters:
- MAX_HOLD, 8: max consecutive cycles one owner keeps grant while others wait (used only with ARB_HOLD_LIMIT_EN); legal range 2..255.
- HOLD_W, 8: width of the hold counter; must hold MAX_HOLD-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector, bit n = requester n.
- grant  output  4  registered one-hot grant; all-zero when idle.
- grant_idx  output  2  binary index of the granted requester; 0 when idle.
- grant_valid  output  1  high iff grant is non-zero.

Behaviour:
- Reset: grant=0000, grant_idx=00, grant_valid=0, ptr=0, hold_cnt=0, state=IDLE. Applied on the clk edge where rst=1, regardless of current state; a mid-grant reset drops the grant at that edge.
- ptr: 2-bit round-robin pointer. Search order is ptr, ptr+1, ... mod 4, so 3 wraps to 0.
- IDLE:
  - If req!=0, select the first set bit at or after ptr. Next edge: state=GRANT and outputs show the owner.
  - Latency is 1 cycle from req sampled to grant visible.
  - If req==0, stay in IDLE with outputs 0.
- GRANT:
  - While req[owner]=1, hold the grant (subject to the hold limit).
  - On the edge where req[owner]=0 is sampled, set ptr=owner+1 mod 4.
  - If any other req bit is set, search from the new ptr and switch grant directly to that requester on the same edge (no idle bubble); hold_cnt=0.
  - Otherwise go to IDLE and clear outputs.
- Simultaneous requests: resolved purely by ptr order, e.g. ptr=2 with req=1111 grants 0100.
- Requests for a non-owner bit never disturb the current grant.
- grant is always one-hot or zero. grant_idx and grant_valid are registered together with grant (same cycle).
- A requester dropping and reasserting is treated as a new request and waits its turn.

Optional Feature:
- ARB_HOLD_LIMIT_EN
  - Defined:
    - hold_cnt increments each cycle in GRANT and resets on every owner change.
    - When hold_cnt==MAX_HOLD-1 and any other req bit is set, force a release: ptr=owner+1, switch to the next requester; the preempted owner re-queues.
    - If no other requester is waiting, hold_cnt saturates at MAX_HOLD-1 and the grant is kept.
  - Not defined: no counter logic; grant is held until the owner drops req.

Decomposition:
- Package arb_pkg: N_REQ=4, IDX_W=2, state enum (IDLE, GRANT), and a function converting one-hot to index.
- One sub-module, rr_pick4: combinational. Takes req[3:0] and ptr[1:0]; returns found, pick_onehot[3:0] and pick_idx[1:0] (rotate, priority-encode, rotate back).
- The top holds the FSM, ptr, hold counter and output registers.

Test Plan:
- Reset while req=1111: outputs 0000/00/0 during rst. First edge after rst=0: grant=0001, idx=00, valid=1.
- From idle, ptr=0: req=0010 for 3 cycles then 0000 → grant=0010, idx=01 one cycle after req rises, held 3 cycles, grant=0000 the cycle after release, ptr=2.
- With ptr=2: req=1011 → grant=1000, idx=11. Drop bit 3 → grant=0001 on the next edge with no bubble (wrap).
- Macro defined, MAX_HOLD=4, req=0011 held → grant alternates 0001 ×4 cycles, 0010 ×4 cycles, and so on. Macro undefined, same stimulus → grant=0001 indefinitely.
- Mid-grant reset: owner 2 granted, assert rst for one cycle → next edge grant=0000, ptr=0. After release, req=0100 → grant=0100.
- Non-owner churn: owner 0 holds while bits 1–3 toggle every cycle → grant stays 0001 and idx stays 00 throughout.
